audio_adc_rx: RTL
=================

Name: audio_adc_rx

Overview:
- I2S receiver for the audio CODEC ADC path (AUD_ADCDAT); the counterpart of the DAC-side serializer that drives AUD_DACDAT.
- The FPGA is I2S master: bit clock and ADC LR clock come from the existing clock generator in the clk domain.
- Deserializes left/right words and presents each stereo frame on a valid/ready interface to the DSP chain.
- Used for line-in capture and for loopback tests against the test-tone path.

Parameters:
- WIDTH, 16, audio word width in bits; range 8..32, must not exceed BCLK periods per half-frame minus 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- aud_bclk  input  1  audio bit clock, clk-synchronous level.
- aud_adclrck  input  1  ADC LR clock; 0 = left, 1 = right.
- aud_adcdat  input  1  serial ADC data from CODEC.
- left  output  WIDTH  left sample, two's complement.
- right  output  WIDTH  right sample, two's complement.
- valid  output  1  frame available in left/right.
- ready  input  1  consumer accepts frame when valid & ready.
- overrun  output  1  sticky: a completed frame was dropped.
- clear  input  1  synchronous clear of overrun.

Behaviour:
- Reset values: left = 0, right = 0, valid = 0, overrun = 0; state = ALIGN, bit counter = 0, shift register = 0.
- Edge detect: bclk_q registers aud_bclk; rise = aud_bclk & ~bclk_q. aud_adcdat and aud_adclrck are sampled only on a rise cycle. lr_q holds the previously sampled LRCK.
- LRCK change = sampled LRCK != lr_q at a rise.
- I2S timing: MSB is at the 2nd BCLK rise after an LRCK transition. The rise that detects the change is the delay slot and is ignored.
- FSM:
  - ALIGN: wait for an LRCK 1->0 change, then go to SHIFT with side = left, count = 0. Ensures the first captured frame is complete.
  - SHIFT: each rise, shift the bit in MSB-first and increment count. When count reaches WIDTH, latch the word into the left or right staging register and go to WAIT.
  - WAIT: ignore further bits. An LRCK 0->1 change starts SHIFT for the right side. An LRCK 1->0 change means the frame is complete and starts SHIFT for the next left word.
  - LRCK change while in SHIFT (short half-frame): discard the partial word and the frame; restart SHIFT for the new side. Never output a partial frame.
- Frame completion: occurs on the first rise at which the right word is latched.
  - If valid = 0, or valid & ready in the same cycle: load left/right from staging on the next clk edge; valid = 1. A simultaneous accept and load keeps valid = 1 with no overrun.
  - If valid & ~ready: keep the old frame, drop the new one, set overrun = 1.
- Accept with no new frame: valid & ready clears valid on the next edge; left/right retain their values.
- clear: overrun -> 0 next edge. If clear coincides with a new overrun event, set wins.
- Latency: valid asserts 1 clk after the clk cycle containing the BCLK rise that samples the right LSB (2 clk more with the sync option).
- Reset mid-operation: immediate return to reset values and state ALIGN; no frame is emitted until a new LRCK 1->0 change.
- count saturates at WIDTH; it never wraps.

Optional Feature:
- Macro ADC_RX_SYNC_EN.
- Defined: aud_bclk, aud_adclrck and aud_adcdat each pass through a 2-flop synchronizer before edge detection. This supports a CODEC-master clock source; latency increases by 2 clk; reset values of the synchronizers are 0.
- Undefined: inputs are used directly (FPGA-master, same-domain timing); no extra latency.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 32 BCLK per half-frame, left = 16'h8001, right = 16'h7FFE, ready = 1.
  - Response: valid pulses 1 clk per frame; left = 8001, right = 7FFE; overrun = 0.
- Alignment:
  - Stimulus: release reset while LRCK = 0, mid left word.
  - Response: no valid until after the next complete 1->0 frame; the first output frame is correct.
- Backpressure:
  - Stimulus: ready = 0 across 2 frames (A = 1111/2222, B = 3333/4444).
  - Response: A is held, overrun = 1; assert clear -> overrun = 0, A still presented.
- Simultaneous accept and load:
  - Stimulus: ready pulsed in the exact cycle the next frame completes.
  - Response: new frame loaded, valid stays 1, overrun = 0.
- Short half-frame:
  - Stimulus: LRCK toggles after 10 bits of the right word.
  - Response: no valid for that frame; the following full frame is output correctly.
- Reset mid-word:
  - Stimulus: reset_n low for 3 clk during SHIFT.
  - Response: all outputs 0 immediately; recovery on the next full frame. Repeat with ADC_RX_SYNC_EN defined: identical data, valid 2 clk later.

Source files
------------

// File: rtl/audio_adc_rx.sv
// I2S receiver for the CODEC ADC path: deserializes left/right words from
// aud_adcdat and presents complete stereo frames on a valid/ready port.
// Optional build macro ADC_RX_SYNC_EN: when defined, aud_bclk, aud_adclrck and
// aud_adcdat each pass through a 2-flop synchronizer (CODEC-master clocking),
// adding 2 clk of latency. Undefined: inputs are used directly.
module audio_adc_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             aud_bclk,
  input  logic             aud_adclrck,
  input  logic             aud_adcdat,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             clear
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic bclk_s;
  logic lrck_s;
  logic dat_s;

`ifdef ADC_RX_SYNC_EN
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;

  // Two-flop synchronizers for a CODEC-sourced bit clock, LR clock and data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      dat_sync  <= 2'b00;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_adclrck};
      dat_sync  <= {dat_sync[0], aud_adcdat};
    end
  end

  assign bclk_s = bclk_sync[1];
  assign lrck_s = lrck_sync[1];
  assign dat_s  = dat_sync[1];
`else
  assign bclk_s = aud_bclk;
  assign lrck_s = aud_adclrck;
  assign dat_s  = aud_adcdat;
`endif

  logic bclk_q;
  logic lr_q;
  logic rise_c;
  logic lr_chg_c;

  assign rise_c   = bclk_s & ~bclk_q;
  assign lr_chg_c = rise_c & (lrck_s != lr_q);

  // BCLK edge history and LRCK value seen at the previous rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_q <= 1'b0;
      lr_q   <= 1'b0;
    end else begin
      bclk_q <= bclk_s;
      if (rise_c) begin
        lr_q <= lrck_s;
      end
    end
  end

  state_t             state, state_d;
  logic               side, side_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [WIDTH-2:0]   shift, shift_d;
  logic [WIDTH-1:0]   left_stage, left_stage_d;
  logic               left_ok, left_ok_d;
  logic [WIDTH-1:0]   shift_ins_c;
  logic               frame_done_c;

  // Word under construction with the current serial bit appended at the LSB
  assign shift_ins_c = {shift, dat_s};

  // State register and capture datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ALIGN;
      side       <= 1'b0;
      count      <= '0;
      shift      <= '0;
      left_stage <= '0;
      left_ok    <= 1'b0;
    end else begin
      state      <= state_d;
      side       <= side_d;
      count      <= count_d;
      shift      <= shift_d;
      left_stage <= left_stage_d;
      left_ok    <= left_ok_d;
    end
  end

  // Next-state: align to a 1->0 LRCK change, shift WIDTH bits, then idle
  // until the next half-frame; any LRCK change mid-word aborts the frame.
  always_comb begin
    state_d      = state;
    side_d       = side;
    count_d      = count;
    shift_d      = shift;
    left_stage_d = left_stage;
    left_ok_d    = left_ok;
    frame_done_c = 1'b0;

    case (state)
      ST_ALIGN: begin
        if (lr_chg_c && !lrck_s) begin
          state_d   = ST_SHIFT;
          side_d    = 1'b0;
          count_d   = '0;
          shift_d   = '0;
          left_ok_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (lr_chg_c) begin
          // Short half-frame: drop the partial word and whatever frame it belonged to
          state_d   = ST_SHIFT;
          side_d    = lrck_s;
          count_d   = '0;
          shift_d   = '0;
          left_ok_d = 1'b0;
        end else if (rise_c) begin
          shift_d = shift_ins_c[WIDTH-2:0];
          if (count == CNT_W'(WIDTH - 1)) begin
            count_d = CNT_W'(WIDTH);
            state_d = ST_WAIT;
            if (!side) begin
              left_stage_d = shift_ins_c;
              left_ok_d    = 1'b1;
            end else begin
              frame_done_c = left_ok;
              left_ok_d    = 1'b0;
            end
          end else if (count < CNT_W'(WIDTH)) begin
            count_d = count + CNT_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (lr_chg_c) begin
          state_d = ST_SHIFT;
          side_d  = lrck_s;
          count_d = '0;
          shift_d = '0;
          if (!lrck_s) begin
            left_ok_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_ALIGN;
      end
    endcase
  end

  // Output frame register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (frame_done_c && (!valid || ready)) begin
        left  <= left_stage;
        right <= shift_ins_c;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (frame_done_c && valid && !ready) begin
        overrun <= 1'b1;
      end else if (clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
